// File: rtl/interrupt_pkg.sv
// Shared types for the interrupt controller: FSM states,
// source encoding and vector-table offsets.
package interrupt_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_e;

  typedef logic [2:0] src_t;

  localparam src_t SRC_NMI  = 3'd0;
  localparam src_t SRC_BRK  = 3'd1;
  localparam src_t SRC_IRQ0 = 3'd2;

  localparam logic [15:0] OFS_NMI  = 16'd0;
  localparam logic [15:0] OFS_BRK  = 16'd2;
  localparam logic [15:0] OFS_IRQ0 = 16'd4;

  function automatic logic [15:0] vec_ofs(src_t s);
    logic [2:0] n;
    n = s - SRC_IRQ0;
    if (s == SRC_NMI)
      return OFS_NMI;
    else if (s == SRC_BRK)
      return OFS_BRK;
    else
      return OFS_IRQ0 + {12'd0, n, 1'b0};
  endfunction

endpackage

// File: rtl/input_synchronizer.sv
// Two-flop synchronizer (reset to 1) with a falling-edge
// detect on the synchronized level.
module input_synchronizer (
  input  logic clk,
  input  logic rst_n,
  input  logic clk_en,
  input  logic d_i,
  output logic q_o,
  output logic fall_o
);

  logic s1_q, s2_q, prev_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q   <= 1'b1;
      s2_q   <= 1'b1;
      prev_q <= 1'b1;
    end else if (clk_en) begin
      s1_q   <= d_i;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end

  assign q_o    = s2_q;
  assign fall_o = ~s2_q & prev_q;

endmodule

// File: rtl/interrupt_controller.sv
// Arbitrates NMI, BRK and maskable IRQs into one request
// held through a req/ack/done handshake with the control unit.
module interrupt_controller
  import interrupt_pkg::*;
#(
  parameter int          NUM_IRQ     = 4,
  parameter logic [15:0] VECTOR_BASE = 16'hFFF0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clk_en,
  input  logic [NUM_IRQ-1:0] irq_n,
  input  logic               nmi_n,
  input  logic               I_FLAG,
  input  logic               brk,
  input  logic               instrBoundary,
  input  logic               intAck,
  input  logic               intDone,
  output logic               intReq,
  output logic [15:0]        vector,
  output logic               bIn
);

  logic [NUM_IRQ-1:0] irq_s;
  logic [NUM_IRQ-1:0] irq_fall_unused;
  logic [NUM_IRQ-1:0] irq_act;
  logic nmi_s_unused, nmi_fall;

  for (genvar g = 0; g < NUM_IRQ; g++) begin : g_irq
    input_synchronizer u_sync (
      .clk    (clk),
      .rst_n  (rst_n),
      .clk_en (clk_en),
      .d_i    (irq_n[g]),
      .q_o    (irq_s[g]),
      .fall_o (irq_fall_unused[g])
    );
  end

  input_synchronizer u_nmi_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .clk_en (clk_en),
    .d_i    (nmi_n),
    .q_o    (nmi_s_unused),
    .fall_o (nmi_fall)
  );

  state_e      state_q, state_d;
  src_t        src_q, src_d, win;
  logic [15:0] vec_q, vec_d;
  logic        nmi_q, nmi_d, nmi_clr, pend;

  assign irq_act = ~irq_s & {NUM_IRQ{~I_FLAG}};

  always_comb begin
    pend = 1'b1;
    win  = SRC_NMI;
    if (nmi_q)
      win = SRC_NMI;
    else if (brk && instrBoundary)
      win = SRC_BRK;
    else if (|irq_act) begin
      // scan downward so the lowest active line is left in win
      for (int n = NUM_IRQ - 1; n >= 0; n--)
        if (irq_act[n]) win = SRC_IRQ0 + src_t'(n);
    end else
      pend = 1'b0;
  end

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    vec_d   = vec_q;
    nmi_clr = 1'b0;
    unique case (state_q)
      IDLE: if (instrBoundary && pend) begin
        src_d   = win;
        vec_d   = VECTOR_BASE + vec_ofs(win);
        state_d = REQ;
      end
      REQ: if (intAck) begin
        state_d = SERVICE;
        nmi_clr = (src_q == SRC_NMI);
      end
      SERVICE: if (intDone) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    nmi_d = nmi_fall | (nmi_q & ~nmi_clr);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      src_q   <= SRC_NMI;
      vec_q   <= 16'h0000;
      nmi_q   <= 1'b0;
    end else if (clk_en) begin
      state_q <= state_d;
      src_q   <= src_d;
      vec_q   <= vec_d;
      nmi_q   <= nmi_d;
    end
  end

  assign intReq = (state_q == REQ);
  assign vector = vec_q;
  assign bIn    = !((state_q == SERVICE) && (src_q == SRC_BRK));

endmodule

// File: tb/tb_interrupt_controller.sv
// Randomized and directed checks of interrupt_controller
// against a cycle-level behavioural model.
module tb_interrupt_controller;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         clk_en = 1'b1;
  logic [N-1:0] irq_n = '1;
  logic         nmi_n = 1'b1;
  logic         I_FLAG = 1'b1;
  logic         brk = 1'b0;
  logic         ib = 1'b0;
  logic         ack = 1'b0;
  logic         done = 1'b0;
  logic         intReq;
  logic [15:0]  vector;
  logic         bIn;

  interrupt_controller #(
    .NUM_IRQ     (N),
    .VECTOR_BASE (16'hFFF0)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .clk_en        (clk_en),
    .irq_n         (irq_n),
    .nmi_n         (nmi_n),
    .I_FLAG        (I_FLAG),
    .brk           (brk),
    .instrBoundary (ib),
    .intAck        (ack),
    .intDone       (done),
    .intReq        (intReq),
    .vector        (vector),
    .bIn           (bIn)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // model: 0 = waiting, 1 = requesting, 2 = in service
  int           m_phase = 0;
  logic [15:0]  m_vec = 16'h0;
  bit           m_isnmi = 0;
  bit           m_isbrk = 0;
  bit           m_nmi = 0;
  logic [N-1:0] ih0 = '1, ih1 = '1;
  logic         nh0 = 1, nh1 = 1, nh2 = 1;

  task automatic take(logic [15:0] v, bit isn, bit isb);
    m_vec   = v;
    m_isnmi = isn;
    m_isbrk = isb;
    m_phase = 1;
  endtask

  task automatic model_edge();
    bit fall;
    if (!rst_n) begin
      m_phase = 0; m_vec = 16'h0; m_isnmi = 0; m_isbrk = 0;
      m_nmi = 0; ih0 = '1; ih1 = '1;
      nh0 = 1; nh1 = 1; nh2 = 1;
      return;
    end
    if (!clk_en) return;
    // lines seen by the logic lag the pins by two enabled edges
    fall = !nh1 && nh2;
    case (m_phase)
      0: if (ib) begin
        if (m_nmi) take(16'hFFF0, 1, 0);
        else if (brk) take(16'hFFF2, 0, 1);
        else if (!I_FLAG && ih1 != '1) begin
          int n;
          n = 0;
          while (ih1[n]) n++;
          take(16'hFFF4 + 16'(2 * n), 0, 0);
        end
      end
      1: if (ack) begin
        m_phase = 2;
        if (m_isnmi) m_nmi = 0;
      end
      default: if (done) m_phase = 0;
    endcase
    if (fall) m_nmi = 1;
    nh2 = nh1; nh1 = nh0; nh0 = nmi_n;
    ih1 = ih0; ih0 = irq_n;
  endtask

  task automatic cyc();
    model_edge();
    @(posedge clk);
    #1;
    check("intReq", intReq, 32'(m_phase == 1));
    check("vector", vector, m_vec);
    check("bIn", bIn, 32'(!(m_phase == 2 && m_isbrk)));
  endtask

  task automatic cycn(int k);
    for (int i = 0; i < k; i++) cyc();
  endtask

  int hold_ok;

  initial begin
    // reset
    rst_n = 0;
    cycn(2);
    check("rst_req", intReq, 0);
    check("rst_vec", vector, 16'h0000);
    check("rst_bin", bIn, 1);

    // IRQ capture and latency
    rst_n = 1; I_FLAG = 0; ib = 1; irq_n = 4'b1110;
    cycn(2);
    check("irq_lat2", intReq, 0);
    cyc();
    check("irq_lat3", intReq, 1);
    check("irq_vec", vector, 16'hFFF4);
    ack = 1; cyc(); ack = 0;
    check("irq_ack", intReq, 0);
    irq_n = '1; ib = 0;
    done = 1; cyc(); done = 0;
    cycn(3);

    // masking
    I_FLAG = 1; irq_n = 4'b0000; ib = 1;
    hold_ok = 1;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (intReq) hold_ok = 0;
    end
    check("mask_hold", hold_ok, 1);
    I_FLAG = 0; cyc();
    check("unmask_vec", vector, 16'hFFF4);
    check("unmask_req", intReq, 1);
    ack = 1; cyc(); ack = 0;
    irq_n = '1; ib = 0;
    done = 1; cyc(); done = 0;
    cycn(3);

    // priority NMI > BRK > IRQ
    nmi_n = 0; irq_n = 4'b1011;
    cycn(3);
    ib = 1; brk = 1; cyc();
    check("prio_nmi", vector, 16'hFFF0);
    ack = 1; cyc(); ack = 0;
    ib = 0; done = 1; cyc(); done = 0;
    ib = 1; cyc();
    check("prio_brk", vector, 16'hFFF2);
    brk = 0; ack = 1; cyc(); ack = 0;
    check("brk_bin", bIn, 0);
    ib = 0; done = 1; cyc(); done = 0;
    check("brk_done", bIn, 1);
    irq_n = '1; nmi_n = 1;
    cycn(4);

    // NMI during service
    nmi_n = 0; ib = 1;
    cycn(4);
    check("nmi_req", vector, 16'hFFF0);
    ack = 1; cyc(); ack = 0;
    nmi_n = 1; cycn(2);
    nmi_n = 0; cycn(4);
    done = 1; cyc(); done = 0;
    cyc();
    check("nmi_again", intReq, 1);
    check("nmi_again_v", vector, 16'hFFF0);
    ack = 1; cyc(); ack = 0;
    done = 1; cyc(); done = 0;
    hold_ok = 1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (intReq) hold_ok = 0;
    end
    check("nmi_single", hold_ok, 1);
    nmi_n = 1; cycn(3);

    // stalls
    irq_n = 4'b1110; I_FLAG = 0; ib = 1;
    cycn(3);
    clk_en = 0;
    for (int i = 0; i < 5; i++) begin
      ack = (i == 2);
      cyc();
    end
    ack = 0;
    check("stall_req", intReq, 1);
    check("stall_vec", vector, 16'hFFF4);
    clk_en = 1; ack = 1; cyc(); ack = 0;
    check("stall_ack", intReq, 0);

    // reset during service with an NMI pending
    nmi_n = 0; cycn(4);
    rst_n = 0; nmi_n = 1; irq_n = '1;
    cyc();
    check("rst2_req", intReq, 0);
    check("rst2_vec", vector, 16'h0000);
    check("rst2_bin", bIn, 1);
    rst_n = 1; ib = 1;
    hold_ok = 1;
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (intReq) hold_ok = 0;
    end
    check("rst2_nmi_clr", hold_ok, 1);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 99) < 3) irq_n = N'($urandom);
      if ($urandom_range(0, 99) < 3) nmi_n = ~nmi_n;
      if ($urandom_range(0, 99) < 5) I_FLAG = ~I_FLAG;
      brk    = ($urandom_range(0, 99) < 10);
      ib     = ($urandom_range(0, 99) < 50);
      ack    = ($urandom_range(0, 99) < 30);
      done   = ($urandom_range(0, 99) < 30);
      clk_en = ($urandom_range(0, 99) < 85);
      rst_n  = ($urandom_range(0, 999) >= 5);
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
